lcd_bus_arbiter: RTL and testbench

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_delay_timer.sv | 39 +++
 rtl/lcd_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_lcd_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD bus arbiter:
//   - FSM state encoding (3-bit constants)
//   - display controller opcodes used by the requesters
//   - default post-command / post-transfer idle lengths (cycles at 12 MHz)
//   - round-robin pick helper for the two requesters
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_CDLY  = 3'd2;
  localparam logic [2:0] ST_PARAM = 3'd3;
  localparam logic [2:0] ST_XDLY  = 3'd4;

  localparam logic [7:0] OP_SLPOUT = 8'h11;
  localparam logic [7:0] OP_CASET  = 8'h2A;
  localparam logic [7:0] OP_RASET  = 8'h2B;
  localparam logic [7:0] OP_RAMWR  = 8'h2C;
  localparam logic [7:0] OP_COLMOD = 8'h3A;

  // 36 cycles = 3 us at 12 MHz
  localparam int DEF_POST_CMD_DLY  = 36;
  localparam int DEF_POST_XFER_DLY = 36;

  localparam int DLY_W = 16;

  // Returns a one-hot grant. On contention the requester that was not
  // granted last wins; last_idx is the index of the previous winner.
  function automatic logic [1:0] rr_pick(input logic [1:0] req,
                                         input logic       last_idx);
    if (req == 2'b11) begin
      return last_idx ? 2'b01 : 2'b10;
    end
    return req;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// ---------------------------------------------------------------------------
// lcd_delay_timer
// Down-counter used for both the post-command and post-transfer idle gaps.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : number of cycles the delay lasts (must be >= 1 when started)
//   start      : load the counter; the following cycle is the first delay cycle
//   expire     : high during the last delay cycle, so the owner can leave its
//                delay state on that edge and the delay lasts exactly 'load'
// ---------------------------------------------------------------------------
module lcd_delay_timer
  import lcd_pkg::*;
#(
  parameter int W = DLY_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] load,
  input  logic         start,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // Count stops at zero, so a stale expire can never appear without a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count == ONE);

endmodule

// File: rtl/lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_bus_arbiter
// Round-robin arbiter that lets two requesters share one SPI byte serializer
// driving an LCD controller. Each transaction is one command byte, an optional
// run of parameter/pixel bytes, and idle gaps after the command and at the end.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req[1:0]            : requester i wants one transaction
//   cmd[15:0]           : {cmd1,cmd0} command byte, sampled at grant
//   len[27:0]           : {len1,len0} 14-bit parameter count, sampled at grant
//   pdata/pvalid/pready : per-requester parameter byte stream
//   gnt[1:0]            : one-hot bus owner, 00 when idle
//   done[1:0]           : one-cycle pulse at transaction end
//   tx_valid/tx_ready   : byte handshake with the serializer
//   tx_byte/tx_dc/tx_last : byte, data/command flag, last byte of transaction
//   busy                : high in every state except IDLE
// ---------------------------------------------------------------------------
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int POST_CMD_DLY  = DEF_POST_CMD_DLY,
  parameter int POST_XFER_DLY = DEF_POST_XFER_DLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [15:0] cmd,
  input  logic [27:0] len,
  input  logic [15:0] pdata,
  input  logic [1:0]  pvalid,
  output logic [1:0]  pready,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_dc,
  output logic        tx_last,
  output logic        busy
);

  localparam logic [DLY_W-1:0] CMD_DLY_V  = DLY_W'(POST_CMD_DLY);
  localparam logic [DLY_W-1:0] XFER_DLY_V = DLY_W'(POST_XFER_DLY);
  // A zero-length gap is skipped outright rather than spending a cycle in it.
  localparam logic [2:0] AFTER_DATA = (POST_XFER_DLY != 0) ? ST_XDLY : ST_IDLE;
  localparam logic [13:0] ONE14 = 14'd1;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [2:0]       after_cmd;
  logic [7:0]       cmd_lat;
  logic [13:0]      remaining;
  logic             last_idx;
  logic             gsel;
  logic             hs;
  logic             finish;
  logic [1:0]       pick;
  logic             dly_start;
  logic [DLY_W-1:0] dly_load;
  logic             dly_expire;

  assign gsel = gnt[1];
  assign pick = rr_pick(req, last_idx);
  assign busy = (state != ST_IDLE);

  // Serializer side. Everything decodes from registered state, so reset
  // clears the outputs without waiting for a clock edge. In PARAM the owner's
  // stream is passed straight through, which stalls cleanly on either side.
  always_comb begin
    tx_valid = 1'b0;
    tx_byte  = 8'h00;
    tx_dc    = 1'b0;
    tx_last  = 1'b0;
    pready   = 2'b00;
    case (state)
      ST_CMD: begin
        tx_valid = 1'b1;
        tx_byte  = cmd_lat;
        tx_last  = (remaining == 14'd0);
      end
      ST_PARAM: begin
        tx_valid = gsel ? pvalid[1] : pvalid[0];
        tx_byte  = gsel ? pdata[15:8] : pdata[7:0];
        tx_dc    = 1'b1;
        tx_last  = (remaining == ONE14);
        pready   = gsel ? {tx_ready, 1'b0} : {1'b0, tx_ready};
      end
      default: ;
    endcase
  end

  assign hs = tx_valid & tx_ready;

  // Transaction sequencing. The remaining count doubles as the latched length:
  // it holds LEN through CMD/CDLY and only moves on parameter handshakes.
  always_comb begin
    after_cmd  = (remaining != 14'd0) ? ST_PARAM : AFTER_DATA;
    next_state = state;
    case (state)
      ST_IDLE:  if (req != 2'b00) next_state = ST_CMD;
      ST_CMD:   if (hs) next_state = (POST_CMD_DLY != 0) ? ST_CDLY : after_cmd;
      ST_CDLY:  if (dly_expire) next_state = after_cmd;
      ST_PARAM: if (hs && remaining == ONE14) next_state = AFTER_DATA;
      ST_XDLY:  if (dly_expire) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Any return to IDLE from a live state ends the transaction; reset does not
  // pass through here, so an abandoned transaction never reports done.
  assign finish    = (state != ST_IDLE) && (next_state == ST_IDLE);
  assign dly_start = (next_state != state) &&
                     ((next_state == ST_CDLY) || (next_state == ST_XDLY));
  assign dly_load  = (next_state == ST_CDLY) ? CMD_DLY_V : XFER_DLY_V;

  lcd_delay_timer #(.W(DLY_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dly_load),
    .start  (dly_start),
    .expire (dly_expire)
  );

  // Grant, latch and round-robin pointer. The pointer moves only when a
  // transaction finishes, so the IDLE cycle carrying done already sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      gnt       <= 2'b00;
      done      <= 2'b00;
      cmd_lat   <= 8'h00;
      remaining <= 14'd0;
      last_idx  <= 1'b1;
    end else begin
      state <= next_state;
      done  <= 2'b00;
      if (state == ST_IDLE && req != 2'b00) begin
        gnt       <= pick;
        cmd_lat   <= pick[1] ? cmd[15:8] : cmd[7:0];
        remaining <= pick[1] ? len[27:14] : len[13:0];
      end
      if (state == ST_PARAM && hs) begin
        remaining <= remaining - ONE14;
      end
      if (finish) begin
        done     <= gnt;
        gnt      <= 2'b00;
        last_idx <= gnt[1];
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_bus_arbiter
// Directed bench for lcd_bus_arbiter with 4-cycle gaps, plus a second copy
// with both gaps set to zero to cover the skipped-delay timing.
// ---------------------------------------------------------------------------
module tb_lcd_bus_arbiter;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] cmd = 16'h0000;
  logic [27:0] len = 28'd0;
  logic [15:0] pdata = 16'h0000;
  logic [1:0]  pvalid = 2'b00;
  logic        tx_ready = 1'b0;

  logic [1:0]  pready, gnt, done;
  logic        tx_valid, tx_dc, tx_last, busy;
  logic [7:0]  tx_byte;

  logic [1:0]  z_pready, z_gnt, z_done;
  logic        z_tx_valid, z_tx_dc, z_tx_last, z_busy;
  logic [7:0]  z_tx_byte;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit toggle_en = 1'b0;
  logic [7:0] pbytes [0:15];

  logic [9:0] byte_log [$];
  int         hs_cyc [$];
  int         done_cyc [$];
  logic [1:0] done_val [$];
  int         z_done_cyc [$];
  logic [1:0] gnt_log [$];
  int         gap_log [$];
  int         stall_log [$];
  int         gap_cnt = 0;
  logic [1:0] prev_gnt = 2'b00;

  lcd_bus_arbiter #(.POST_CMD_DLY(4), .POST_XFER_DLY(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .len(len),
    .pdata(pdata), .pvalid(pvalid), .pready(pready), .gnt(gnt), .done(done),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .tx_dc(tx_dc), .tx_last(tx_last), .busy(busy)
  );

  lcd_bus_arbiter #(.POST_CMD_DLY(0), .POST_XFER_DLY(0)) dut_zero (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .len(len),
    .pdata(pdata), .pvalid(pvalid), .pready(z_pready), .gnt(z_gnt), .done(z_done),
    .tx_valid(z_tx_valid), .tx_ready(tx_ready), .tx_byte(z_tx_byte),
    .tx_dc(z_tx_dc), .tx_last(z_tx_last), .busy(z_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the serializer side and the grant/done lines mid-cycle.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      byte_log.push_back({tx_dc, tx_last, tx_byte});
      hs_cyc.push_back(cyc);
    end
    if (done != 2'b00) begin
      done_cyc.push_back(cyc);
      done_val.push_back(done);
    end
    if (z_done != 2'b00) z_done_cyc.push_back(cyc);
    if (tx_dc && !tx_valid) stall_log.push_back(cyc);
    if (gnt == 2'b00) begin
      gap_cnt <= gap_cnt + 1;
    end else if (prev_gnt == 2'b00) begin
      gnt_log.push_back(gnt);
      gap_log.push_back(gap_cnt);
      gap_cnt <= 0;
    end
    prev_gnt <= gnt;
  end

  // TX_READY toggles every cycle while enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (toggle_en) tx_ready = ~tx_ready;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [15:0] c,
                               input logic [27:0] l);
    req = r;
    cmd = c;
    len = l;
  endtask

  task automatic clearLogs();
    byte_log.delete(); hs_cyc.delete(); done_cyc.delete(); done_val.delete();
    z_done_cyc.delete(); gnt_log.delete(); gap_log.delete(); stall_log.delete();
  endtask

  task automatic waitGrant(input int bound);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (gnt == 2'b00 && k < bound);
    checkOutput("grant_wait", 32'(gnt == 2'b00), 32'd0);
  endtask

  task automatic waitDoneCount(input int n, input int bound);
    int k = 0;
    while (done_val.size() < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    checkOutput("done_wait", 32'(done_val.size() < n), 32'd0);
  endtask

  // Present parameter bytes for requester g; a byte advances only when it was
  // valid and pready was seen in the same cycle. gap_len cycles of pvalid low
  // are inserted when byte gap_at is due.
  task automatic feed(input int g, input int n, input bit pix,
                      input int gap_at, input int gap_len);
    int i = 0;
    int guard = 0;
    int gl = gap_len;
    bit took;
    logic [7:0] b;
    @(posedge clk); #1;
    while (i < n && guard < 40000) begin
      if (i == gap_at && gl > 0) begin
        pvalid[g] = 1'b0;
        gl--;
      end else begin
        b = pix ? 8'(i) : pbytes[i[3:0]];
        pvalid[g] = 1'b1;
        if (g == 0) pdata[7:0] = b;
        else        pdata[15:8] = b;
      end
      @(negedge clk);
      took = pvalid[g] && pready[g];
      @(posedge clk); #1;
      if (took) i++;
      guard++;
    end
    pvalid[g] = 1'b0;
    checkOutput("feed_bound", 32'(guard >= 40000), 32'd0);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int errs;
    logic [9:0] exp_e;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    checkOutput("rst_gnt", gnt, 2'b00);
    checkOutput("rst_done", done, 2'b00);
    checkOutput("rst_pready", pready, 2'b00);
    checkOutput("rst_tx_valid", tx_valid, 1'b0);
    checkOutput("rst_tx_byte", tx_byte, 8'h00);
    checkOutput("rst_tx_dc", tx_dc, 1'b0);
    checkOutput("rst_tx_last", tx_last, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- single command, no parameters ----
    clearLogs();
    tx_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(2'b01, {8'h00, OP_SLPOUT}, 28'd0);
    waitGrant(20);
    checkOutput("t1_gnt", gnt, 2'b01);
    req = 2'b00;
    waitDoneCount(1, 100);
    repeat (5) @(negedge clk);
    checkOutput("t1_nbytes", byte_log.size(), 1);
    checkOutput("t1_byte", byte_log[0], {2'b01, 8'h11});
    checkOutput("t1_done_lat", done_cyc[0] - hs_cyc[0], 9);
    checkOutput("t1_done_val", done_val[0], 2'b01);
    checkOutput("t1_ndone", done_val.size(), 1);
    checkOutput("t1_zero_dly_lat", z_done_cyc[0] - hs_cyc[0], 1);
    checkOutput("t1_gnt_clear", gnt, 2'b00);

    // ---- parameters with TX_READY toggling ----
    clearLogs();
    pbytes[0] = 8'h00; pbytes[1] = 8'h01; pbytes[2] = 8'h00; pbytes[3] = 8'hA0;
    @(posedge clk); #1;
    toggle_en = 1'b1;
    applyStimulus(2'b10, {OP_CASET, 8'h00}, {14'd4, 14'd0});
    waitGrant(20);
    checkOutput("t2_gnt", gnt, 2'b10);
    req = 2'b00;
    feed(1, 4, 1'b0, -1, 0);
    waitDoneCount(1, 100);
    toggle_en = 1'b0;
    @(posedge clk); #1 tx_ready = 1'b1;
    checkOutput("t2_nbytes", byte_log.size(), 5);
    checkOutput("t2_b0", byte_log[0], {2'b00, 8'h2A});
    checkOutput("t2_b1", byte_log[1], {2'b10, 8'h00});
    checkOutput("t2_b2", byte_log[2], {2'b10, 8'h01});
    checkOutput("t2_b3", byte_log[3], {2'b10, 8'h00});
    checkOutput("t2_b4", byte_log[4], {2'b11, 8'hA0});
    checkOutput("t2_done_val", done_val[0], 2'b10);

    // ---- contention after reset ----
    pulseReset();
    clearLogs();
    applyStimulus(2'b11, {OP_RASET, OP_COLMOD}, 28'd0);
    begin
      int k = 0;
      while (gnt_log.size() < 4 && k < 500) begin
        @(negedge clk);
        k++;
      end
      checkOutput("t3_grant_wait", 32'(gnt_log.size() < 4), 32'd0);
    end
    req = 2'b00;
    waitDoneCount(4, 200);
    repeat (3) @(negedge clk);
    checkOutput("t3_g0", gnt_log[0], 2'b01);
    checkOutput("t3_g1", gnt_log[1], 2'b10);
    checkOutput("t3_g2", gnt_log[2], 2'b01);
    checkOutput("t3_g3", gnt_log[3], 2'b10);
    checkOutput("t3_gap1", gap_log[1], 1);
    checkOutput("t3_gap2", gap_log[2], 1);
    checkOutput("t3_gap3", gap_log[3], 1);
    checkOutput("t3_b0", byte_log[0], {2'b01, 8'h3A});
    checkOutput("t3_b1", byte_log[1], {2'b01, 8'h2B});
    checkOutput("t3_ngrants", gnt_log.size(), 4);

    // ---- PVALID gap mid-burst ----
    clearLogs();
    pbytes[0] = 8'hC0; pbytes[1] = 8'hC1; pbytes[2] = 8'hC2;
    @(posedge clk); #1;
    applyStimulus(2'b01, {8'h00, OP_RASET}, {14'd0, 14'd3});
    waitGrant(20);
    req = 2'b00;
    feed(0, 3, 1'b0, 1, 5);
    waitDoneCount(1, 100);
    checkOutput("t4_stall", stall_log.size(), 5);
    checkOutput("t4_nbytes", byte_log.size(), 4);
    checkOutput("t4_b1", byte_log[1], {2'b10, 8'hC0});
    checkOutput("t4_b2", byte_log[2], {2'b10, 8'hC1});
    checkOutput("t4_b3", byte_log[3], {2'b11, 8'hC2});

    // ---- reset in PARAM with two bytes left ----
    clearLogs();
    pbytes[0] = 8'h10; pbytes[1] = 8'h20;
    @(posedge clk); #1;
    applyStimulus(2'b01, {8'h00, OP_RAMWR}, {14'd0, 14'd4});
    waitGrant(20);
    req = 2'b00;
    feed(0, 2, 1'b0, -1, 0);
    pvalid[0] = 1'b1;
    pdata[7:0] = 8'h55;
    tx_ready = 1'b1;
    #2;
    checkOutput("t5_pre_valid", tx_valid, 1'b1);
    checkOutput("t5_pre_byte", tx_byte, 8'h55);
    checkOutput("t5_pre_pready", pready, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_gnt", gnt, 2'b00);
    checkOutput("t5_pready", pready, 2'b00);
    checkOutput("t5_tx_valid", tx_valid, 1'b0);
    checkOutput("t5_tx_byte", tx_byte, 8'h00);
    checkOutput("t5_tx_dc", tx_dc, 1'b0);
    checkOutput("t5_tx_last", tx_last, 1'b0);
    checkOutput("t5_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    pvalid = 2'b00;
    applyStimulus(2'b11, {OP_CASET, OP_RASET}, 28'd0);
    rst_n = 1'b1;
    checkOutput("t5_no_done", done_val.size(), 0);
    waitGrant(20);
    checkOutput("t5_rr_after_rst", gnt, 2'b01);
    req = 2'b00;
    waitDoneCount(1, 100);
    checkOutput("t5_done_val", done_val[0], 2'b01);

    // ---- long pixel burst ----
    clearLogs();
    @(posedge clk); #1;
    applyStimulus(2'b01, {8'h00, OP_RAMWR}, {14'd0, 14'd12800});
    waitGrant(20);
    req = 2'b00;
    feed(0, 12800, 1'b1, -1, 0);
    waitDoneCount(1, 200);
    repeat (10) @(negedge clk);
    checkOutput("t6_nbytes", byte_log.size(), 12801);
    checkOutput("t6_cmd", byte_log[0], {2'b00, 8'h2C});
    errs = 0;
    for (int i = 1; i < byte_log.size(); i++) begin
      exp_e = {1'b1, (i == 12800), 8'(i - 1)};
      if (byte_log[i] !== exp_e) errs++;
    end
    checkOutput("t6_order", errs, 0);
    checkOutput("t6_ndone", done_val.size(), 1);
    checkOutput("t6_done_val", done_val[0], 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
